// File: rtl/pipe_mem_ctrl_pkg.sv
// Shared pipeline definitions for the memory stage: access-size encodings and
// the sequencer state type.
package pipe_mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StErr  = 2'b10
  } mem_state_e;

endpackage

// File: rtl/pipe_mem_fmt.sv
// Combinational lane logic: byte enables, store-lane replication, load lane
// extraction with sign/zero extension, and alignment check.
module pipe_mem_fmt
  import pipe_mem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_shift   = rdata_i >> {addr_lo_i, 3'b000};
    rd_byte    = rd_shift[7:0];
    rd_half    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    load_o     = rdata_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = {{24{sign_i & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        load_o     = {{16{sign_i & rd_half[15]}}, rd_half};
        misalign_o = addr_lo_i[0];
      end
      // SZ_WORD and the reserved 2'b11 encoding both behave as word
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/pipe_mem_ctrl.sv
// Memory-stage sequencer: data-memory handshake, pipeline freeze, bus timeout,
// alignment fault and stall-cycle performance counter.
module pipe_mem_ctrl
  import pipe_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_mem_ren,
  input  logic             in_mem_wen,
  input  logic [1:0]       in_size,
  input  logic             in_sign,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic             in_dmem_ack,
  input  logic [31:0]      in_dmem_rdata,
  output logic             out_dmem_req,
  output logic             out_dmem_we,
  output logic [31:0]      out_dmem_addr,
  output logic [3:0]       out_dmem_be,
  output logic [31:0]      out_dmem_wdata,
  output logic             out_stall,
  output logic             out_wb_kill,
  output logic [31:0]      out_load_data,
  output logic             out_addr_err,
  output logic             out_bus_err,
  output logic [CNT_W-1:0] out_stall_cycles
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 2);

  mem_state_e       state_q;
  logic [TmoW-1:0]  tmo_q;
  logic [CNT_W-1:0] perf_q;

  logic        acc, is_load, misalign;
  logic        req, stall, kill, addr_err, bus_err;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_load;

  assign acc     = in_mem_ren | in_mem_wen;
  assign is_load = in_mem_ren & ~in_mem_wen;

  pipe_mem_fmt u_fmt (
    .size_i     (in_size),
    .sign_i     (in_sign),
    .addr_lo_i  (in_addr[1:0]),
    .wdata_i    (in_wdata),
    .rdata_i    (in_dmem_rdata),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .load_o     (fmt_load),
    .misalign_o (misalign)
  );

  // Gated by reset so an asserted reset drops the request combinationally.
  always_comb begin
    req      = 1'b0;
    stall    = 1'b0;
    kill     = 1'b0;
    addr_err = 1'b0;
    bus_err  = 1'b0;
    if (!in_rst) begin
      unique case (state_q)
        StIdle: begin
          if (acc && misalign) begin
            addr_err = 1'b1;
            kill     = 1'b1;
          end else if (acc) begin
            req   = 1'b1;
            stall = ~in_dmem_ack;
          end
        end
        StWait: begin
          req   = 1'b1;
          stall = ~in_dmem_ack;
        end
        StErr: begin
          bus_err = 1'b1;
          kill    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      perf_q  <= '0;
    end else begin
      if (stall && (perf_q != {CNT_W{1'b1}})) begin
        perf_q <= perf_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (req && !in_dmem_ack) begin
            state_q <= StWait;
            tmo_q   <= '0;
          end
        end
        StWait: begin
          if (in_dmem_ack) begin
            state_q <= StIdle;
          end else if (tmo_q == TmoLast) begin
            state_q <= StErr;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_dmem_req     = req;
  assign out_dmem_we      = req & in_mem_wen;
  assign out_dmem_addr    = req ? {in_addr[31:2], 2'b00} : 32'h0;
  assign out_dmem_be      = req ? fmt_be : 4'b0000;
  assign out_dmem_wdata   = out_dmem_we ? fmt_wdata : 32'h0;
  assign out_stall        = stall;
  assign out_wb_kill      = kill;
  assign out_load_data    = (req && in_dmem_ack && is_load) ? fmt_load : 32'h0;
  assign out_addr_err     = addr_err;
  assign out_bus_err      = bus_err;
  assign out_stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Self-checking bench for pipe_mem_ctrl: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_pipe_mem_ctrl;

  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 5;
  localparam int unsigned PERF_MAX = (1 << CW) - 1;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b1;
  logic          in_mem_ren = 1'b0, in_mem_wen = 1'b0;
  logic [1:0]    in_size = 2'b00;
  logic          in_sign = 1'b0;
  logic [31:0]   in_addr = 32'h0, in_wdata = 32'h0, in_dmem_rdata = 32'h0;
  logic          in_dmem_ack = 1'b0;
  logic          out_dmem_req, out_dmem_we, out_stall, out_wb_kill;
  logic          out_addr_err, out_bus_err;
  logic [31:0]   out_dmem_addr, out_dmem_wdata, out_load_data;
  logic [3:0]    out_dmem_be;
  logic [CW-1:0] out_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int model_perf = 0;

  pipe_mem_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_mem_ren       (in_mem_ren),
    .in_mem_wen       (in_mem_wen),
    .in_size          (in_size),
    .in_sign          (in_sign),
    .in_addr          (in_addr),
    .in_wdata         (in_wdata),
    .in_dmem_ack      (in_dmem_ack),
    .in_dmem_rdata    (in_dmem_rdata),
    .out_dmem_req     (out_dmem_req),
    .out_dmem_we      (out_dmem_we),
    .out_dmem_addr    (out_dmem_addr),
    .out_dmem_be      (out_dmem_be),
    .out_dmem_wdata   (out_dmem_wdata),
    .out_stall        (out_stall),
    .out_wb_kill      (out_wb_kill),
    .out_load_data    (out_load_data),
    .out_addr_err     (out_addr_err),
    .out_bus_err      (out_bus_err),
    .out_stall_cycles (out_stall_cycles)
  );

  always #5 in_clk = ~in_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: access rules as plain arithmetic.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return (a[1] ? 4'd12 : 4'd3);
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * a[1:0])) & 32'hFF;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (r >> (16 * a[1])) & 32'hFFFF;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return r;
  endfunction

  function automatic logic m_misalign(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return (a % 4) != 0;
  endfunction

  // Checks every output at the negedge, then advances the perf-counter model.
  task automatic check_cycle(input string tag, input logic req, input logic we,
                             input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input logic stall, input logic kill,
                             input logic [31:0] ld, input logic aerr, input logic berr);
    @(negedge in_clk);
    check_eq({tag, ".req"},   32'(out_dmem_req),     32'(req));
    check_eq({tag, ".we"},    32'(out_dmem_we),      32'(we));
    check_eq({tag, ".addr"},  out_dmem_addr,         addr);
    check_eq({tag, ".be"},    32'(out_dmem_be),      32'(be));
    check_eq({tag, ".wdata"}, out_dmem_wdata,        wd);
    check_eq({tag, ".stall"}, 32'(out_stall),        32'(stall));
    check_eq({tag, ".kill"},  32'(out_wb_kill),      32'(kill));
    check_eq({tag, ".ld"},    out_load_data,         ld);
    check_eq({tag, ".aerr"},  32'(out_addr_err),     32'(aerr));
    check_eq({tag, ".berr"},  32'(out_bus_err),      32'(berr));
    check_eq({tag, ".perf"},  32'(out_stall_cycles), 32'(model_perf));
    if (stall && model_perf < PERF_MAX) model_perf++;
  endtask

  // Called just after a rising edge; returns just after the edge ending the access.
  // lat = cycle index in which ack arrives; lat >= TMO means it never arrives in time.
  task automatic run_txn(input string tag, input logic ren, input logic wen,
                         input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int lat);
    logic        st, ld_op;
    logic [31:0] waddr, exp_wd;
    logic [3:0]  be;
    st     = wen;
    ld_op  = ren & ~wen;
    waddr  = a & 32'hFFFF_FFFC;
    be     = m_be(sz, a);
    exp_wd = st ? m_wdata(sz, wd) : 32'h0;
    in_mem_ren = ren; in_mem_wen = wen; in_size = sz; in_sign = sg;
    in_addr = a; in_wdata = wd;
    if (!(ren | wen)) begin
      in_dmem_ack = 1'($urandom_range(0, 1));
      in_dmem_rdata = $urandom;
      check_cycle({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge in_clk); #1;
    end else if (m_misalign(sz, a)) begin
      in_dmem_ack = 1'($urandom_range(0, 1));
      in_dmem_rdata = $urandom;
      check_cycle({tag, ".mis"}, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      @(posedge in_clk); #1;
    end else begin
      for (int k = 0; k <= int'(TMO); k++) begin
        if (k < int'(TMO) && k == lat) begin
          in_dmem_ack = 1'b1;
          in_dmem_rdata = rd;
          check_cycle({tag, ".ack"}, 1, st, waddr, be, exp_wd, 0, 0,
                      ld_op ? m_load(sz, sg, a, rd) : 32'h0, 0, 0);
          @(posedge in_clk); #1;
          break;
        end else if (k < int'(TMO)) begin
          in_dmem_ack = 1'b0;
          in_dmem_rdata = $urandom;
          check_cycle({tag, ".wait"}, 1, st, waddr, be, exp_wd, 1, 0, 0, 0, 0);
          @(posedge in_clk); #1;
        end else begin
          in_dmem_ack = 1'($urandom_range(0, 1));
          in_dmem_rdata = $urandom;
          check_cycle({tag, ".berr"}, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
          @(posedge in_clk); #1;
        end
      end
    end
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_dmem_ack = 1'b0;
  endtask

  initial begin
    logic [1:0] sz;
    logic       r, w;
    int         lat;
    #7;
    check_eq("rst.req",   32'(out_dmem_req),     0);
    check_eq("rst.stall", 32'(out_stall),        0);
    check_eq("rst.perf",  32'(out_stall_cycles), 0);
    #5 in_rst = 1'b0;
    @(posedge in_clk); #1;

    run_txn("word_ld0", 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn("sbyte_ld", 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_FFFF, 3);
    check_eq("perf3", 32'(out_stall_cycles), 3);
    run_txn("half_st", 0, 1, 2'd1, 0, 32'h202, 32'h1234, 32'h0, 1);
    run_txn("mis_word", 1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0);
    run_txn("timeout", 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 1000);
    run_txn("idle_ack", 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 0);

    // Reset asserted in the second WAIT cycle of a load that never gets acked.
    in_mem_ren = 1'b1; in_size = 2'd2; in_addr = 32'h400; in_dmem_ack = 1'b0;
    check_cycle("rstw.c0", 1, 0, 32'h400, 4'hF, 0, 1, 0, 0, 0, 0);
    @(posedge in_clk); #1;
    check_cycle("rstw.c1", 1, 0, 32'h400, 4'hF, 0, 1, 0, 0, 0, 0);
    @(posedge in_clk); #2;
    in_rst = 1'b1;
    #1;
    check_eq("rstw.req",   32'(out_dmem_req),     0);
    check_eq("rstw.stall", 32'(out_stall),        0);
    check_eq("rstw.addr",  out_dmem_addr,         0);
    check_eq("rstw.be",    32'(out_dmem_be),      0);
    check_eq("rstw.perf",  32'(out_stall_cycles), 0);
    model_perf = 0;
    in_mem_ren = 1'b0;
    @(posedge in_clk); #2;
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    check_cycle("rstw.after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge in_clk); #1;

    for (int i = 0; i < 300; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin r = 1'b0; w = 1'b0; end
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       lat = int'(TMO) - 1;
        1:       lat = int'(TMO);
        2:       lat = int'(TMO) + 3;
        default: lat = $urandom_range(0, 5);
      endcase
      run_txn($sformatf("rnd%0d", i), r, w, sz, 1'($urandom_range(0, 1)), $urandom,
              $urandom, $urandom, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
